// File: rtl/vend_pkg.sv
// Shared encodings for the coin token feeder: FSM states, denomination codes
// and the denomination-to-token lookup.
package vend_pkg;

  localparam int STATE_W = 3;
  localparam int TOK_W   = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_DEBOUNCE = 3'd1;
  localparam logic [STATE_W-1:0] ST_ACCEPT   = 3'd2;
  localparam logic [STATE_W-1:0] ST_EMIT     = 3'd3;
  localparam logic [STATE_W-1:0] ST_GAP      = 3'd4;
  localparam logic [STATE_W-1:0] ST_RELEASE  = 3'd5;

  localparam logic [1:0] COIN_1   = 2'b00;
  localparam logic [1:0] COIN_2   = 2'b01;
  localparam logic [1:0] COIN_5   = 2'b10;
  localparam logic [1:0] COIN_BAD = 2'b11;

  function automatic logic [TOK_W-1:0] token_count(input logic [1:0] sel);
    logic [TOK_W-1:0] n;
    case (sel)
      COIN_1:  n = TOK_W'(1);
      COIN_2:  n = TOK_W'(2);
      COIN_5:  n = TOK_W'(5);
      default: n = '0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// Two-flop synchronizer for the coin sensor plus a stability counter that
// measures how long the synchronized level has been unchanged.
module coin_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic coin_i,
  input  logic clr_i,
  output logic cs_o,
  output logic stable_hi_o,
  output logic stable_lo_o
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             meta_q;
  logic             cs_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Restart when the level is about to change so cnt_q counts cycles of the
  // current cs level; saturates so a long-settled level reads stable at once.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || (meta_q != cs_q)) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      cs_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= coin_i;
      cs_q   <= meta_q;
      cnt_q  <= cnt_d;
    end
  end

  assign cs_o        = cs_q;
  assign stable_hi_o = cs_q && (cnt_q == CNT_MAX);
  assign stable_lo_o = !cs_q && (cnt_q == CNT_MAX);

endmodule

// File: rtl/coin_token_feeder.sv
// Coin acceptor front end: debounces the slot sensor, classifies the coin and
// emits a paced train of registered token pulses with credit and error tracking.
module coin_token_feeder
  import vend_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int JAM_CYCLES = 64,
  parameter int TOKEN_GAP  = 2,
  parameter int CW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin_in,
  input  logic [1:0]    coin_sel,
  output logic          T,
  output logic          busy,
  output logic [CW-1:0] credit,
  output logic          err
);

  localparam int GAP_W = (TOKEN_GAP > 1) ? $clog2(TOKEN_GAP) : 1;
  localparam int JAM_W = $clog2(JAM_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TOKEN_GAP - 1);
  localparam logic [JAM_W-1:0] JAM_MAX  = JAM_W'(JAM_CYCLES);
  localparam logic [JAM_W-1:0] JAM_LAST = JAM_W'(JAM_CYCLES - 1);

  logic cs;
  logic stable_hi;
  logic stable_lo;
  logic deb_clr;

  state_t           state_q, state_d;
  logic [TOK_W-1:0] tok_q, tok_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [JAM_W-1:0] jam_q, jam_d;
  logic [1:0]       sel_q, sel_d;
  logic             t_q, t_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    credit_q, credit_d;
  logic             err_q, err_d;
  logic             emit_go;

  coin_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk_i       (clk),
    .rst_ni      (rst),
    .coin_i      (coin_in),
    .clr_i       (deb_clr),
    .cs_o        (cs),
    .stable_hi_o (stable_hi),
    .stable_lo_o (stable_lo)
  );

  always_comb begin
    state_d  = state_q;
    tok_d    = tok_q;
    gap_d    = gap_q;
    jam_d    = jam_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    credit_d = credit_q;
    err_d    = err_q;
    deb_clr  = 1'b0;
    emit_go  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        deb_clr = 1'b1;
        if (cs) begin
          state_d = ST_DEBOUNCE;
        end
      end

      ST_DEBOUNCE: begin
        if (!cs) begin
          state_d = ST_IDLE;
        end else if (stable_hi) begin
          // Busy covers the accept cycle itself, but only for a coin that will pay out.
          state_d = ST_ACCEPT;
          sel_d   = coin_sel;
          busy_d  = (coin_sel != COIN_BAD);
        end
      end

      ST_ACCEPT: begin
        if (sel_q == COIN_BAD) begin
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          tok_d   = token_count(sel_q);
          emit_go = 1'b1;
          state_d = ST_EMIT;
        end
      end

      ST_EMIT: begin
        tok_d   = tok_q - TOK_W'(1);
        gap_d   = '0;
        state_d = ST_GAP;
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (tok_q != '0) begin
            emit_go = 1'b1;
            state_d = ST_EMIT;
          end else begin
            busy_d  = 1'b0;
            state_d = ST_RELEASE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      ST_RELEASE: begin
        if (stable_lo) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The pulse is registered on entry to EMIT, so T is high exactly during EMIT.
    if (emit_go && (credit_q != '1)) begin
      credit_d = credit_q + CW'(1);
    end

    // A jam only flags the error; any payout in progress carries on.
    if (cs && (state_q != ST_IDLE)) begin
      if (jam_q != JAM_MAX) begin
        jam_d = jam_q + JAM_W'(1);
      end
      if (jam_q == JAM_LAST) begin
        err_d = 1'b1;
      end
    end else begin
      jam_d = '0;
    end
  end

  assign t_d = emit_go;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      tok_q    <= '0;
      gap_q    <= '0;
      jam_q    <= '0;
      sel_q    <= COIN_1;
      t_q      <= 1'b0;
      busy_q   <= 1'b0;
      credit_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tok_q    <= tok_d;
      gap_q    <= gap_d;
      jam_q    <= jam_d;
      sel_q    <= sel_d;
      t_q      <= t_d;
      busy_q   <= busy_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign T      = t_q;
  assign busy   = busy_q;
  assign credit = credit_q;
  assign err    = err_q;

endmodule

// File: tb/tb_coin_token_feeder.sv
// Directed bench for coin_token_feeder at default parameters.
module tb_coin_token_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_in;
  logic [1:0] coin_sel;
  logic       T;
  logic       busy;
  logic [7:0] credit;
  logic       err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int   tcount      = 0;
  int   t_times[$];
  int   busy_cycles = 0;
  int   busy_fall   = -1;
  int   err_rise    = -1;
  logic busy_prev   = 1'b0;
  logic err_prev    = 1'b0;

  coin_token_feeder dut (
    .clk      (clk),
    .rst      (rst),
    .coin_in  (coin_in),
    .coin_sel (coin_sel),
    .T        (T),
    .busy     (busy),
    .credit   (credit),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (T === 1'b1) begin
      tcount <= tcount + 1;
      t_times.push_back(cyc);
    end
    if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
    if (busy_prev === 1'b1 && busy === 1'b0) busy_fall <= cyc;
    if (err_prev === 1'b0 && err === 1'b1) err_rise <= cyc;
    busy_prev <= busy;
    err_prev  <= err;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    coin_in = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    coin_in  = 1'b0;
    coin_sel = 2'b00;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (T !== 1'b0) begin failures++; $display("FAIL reset_T: got %b expected 0", T); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (credit !== 8'd0) begin failures++; $display("FAIL reset_credit: got %0d expected 0", credit); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
    tick(3);
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_single();
    int c0, n0, i0, b0, lat;
    n0 = tcount; i0 = t_times.size(); b0 = busy_cycles;
    coin_sel = 2'b00;
    c0 = cyc;
    coin_in = 1'b1;
    tick(20);
    coin_in = 1'b0;
    tick(15);
    lat = (t_times.size() > i0) ? t_times[i0] - c0 : -1;
    checks++; if (tcount - n0 !== 1) begin failures++; $display("FAIL single_tokens: got %0d expected 1", tcount - n0); end
    checks++; if (lat !== 8) begin failures++; $display("FAIL single_latency: got %0d expected 8", lat); end
    checks++; if (credit !== 8'd1) begin failures++; $display("FAIL single_credit: got %0d expected 1", credit); end
    checks++; if (busy_cycles - b0 !== 4) begin failures++; $display("FAIL single_busy_len: got %0d expected 4", busy_cycles - b0); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err: got %b expected 0", err); end
  endtask

  task automatic test_denom5();
    int c0, n0, i0, lat, bad, lastt;
    n0 = tcount; i0 = t_times.size();
    coin_sel = 2'b10;
    c0 = cyc;
    coin_in = 1'b1;
    tick(40);
    coin_in = 1'b0;
    tick(15);
    lat = (t_times.size() > i0) ? t_times[i0] - c0 : -1;
    bad = 0;
    for (int k = i0 + 1; k < t_times.size(); k++) begin
      if (t_times[k] - t_times[k-1] != 3) bad++;
    end
    lastt = (t_times.size() > i0) ? t_times[t_times.size()-1] : -100;
    checks++; if (tcount - n0 !== 5) begin failures++; $display("FAIL denom5_tokens: got %0d expected 5", tcount - n0); end
    checks++; if (lat !== 8) begin failures++; $display("FAIL denom5_latency: got %0d expected 8", lat); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL denom5_spacing: got %0d bad gaps expected 0", bad); end
    checks++; if (credit !== 8'd6) begin failures++; $display("FAIL denom5_credit: got %0d expected 6", credit); end
    checks++; if (busy_fall - lastt !== 3) begin failures++; $display("FAIL denom5_busy_fall: got %0d expected 3", busy_fall - lastt); end
  endtask

  task automatic test_glitch();
    int c0, n0, i0, b0, lat;
    n0 = tcount; b0 = busy_cycles;
    coin_sel = 2'b00;
    coin_in = 1'b1;
    tick(2);
    coin_in = 1'b0;
    tick(20);
    checks++; if (tcount - n0 !== 0) begin failures++; $display("FAIL glitch_tokens: got %0d expected 0", tcount - n0); end
    checks++; if (credit !== 8'd6) begin failures++; $display("FAIL glitch_credit: got %0d expected 6", credit); end
    checks++; if (busy_cycles - b0 !== 0) begin failures++; $display("FAIL glitch_busy: got %0d expected 0", busy_cycles - b0); end
    i0 = t_times.size();
    c0 = cyc;
    coin_in = 1'b1;
    tick(20);
    coin_in = 1'b0;
    tick(15);
    lat = (t_times.size() > i0) ? t_times[i0] - c0 : -1;
    checks++; if (lat !== 8) begin failures++; $display("FAIL glitch_next_latency: got %0d expected 8", lat); end
    checks++; if (credit !== 8'd7) begin failures++; $display("FAIL glitch_next_credit: got %0d expected 7", credit); end
  endtask

  task automatic test_invalid();
    int n0;
    n0 = tcount;
    coin_sel = 2'b11;
    coin_in = 1'b1;
    tick(20);
    coin_in = 1'b0;
    tick(15);
    checks++; if (tcount - n0 !== 0) begin failures++; $display("FAIL invalid_tokens: got %0d expected 0", tcount - n0); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL invalid_err: got %b expected 1", err); end
    checks++; if (credit !== 8'd7) begin failures++; $display("FAIL invalid_credit: got %0d expected 7", credit); end
  endtask

  task automatic test_jam();
    int c0, n0;
    do_reset();
    n0 = tcount;
    coin_sel = 2'b00;
    c0 = cyc;
    coin_in = 1'b1;
    tick(30);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL jam_err_early: got %b expected 0", err); end
    tick(70);
    checks++; if (err_rise - c0 !== 67) begin failures++; $display("FAIL jam_err_time: got %0d expected 67", err_rise - c0); end
    checks++; if (tcount - n0 !== 1) begin failures++; $display("FAIL jam_tokens: got %0d expected 1", tcount - n0); end
    // A short low dip does not satisfy the release wait, so this insertion is ignored.
    coin_in = 1'b0;
    tick(2);
    coin_in = 1'b1;
    tick(10);
    coin_in = 1'b0;
    tick(15);
    checks++; if (tcount - n0 !== 1) begin failures++; $display("FAIL jam_reinsert_ignored: got %0d expected 1", tcount - n0); end
    coin_sel = 2'b01;
    coin_in = 1'b1;
    tick(20);
    coin_in = 1'b0;
    tick(15);
    checks++; if (credit !== 8'd3) begin failures++; $display("FAIL jam_next_credit: got %0d expected 3", credit); end
  endtask

  task automatic test_saturation();
    int n0;
    do_reset();
    n0 = tcount;
    coin_sel = 2'b10;
    for (int i = 0; i < 60; i++) begin
      coin_in = 1'b1;
      tick(10);
      coin_in = 1'b0;
      tick(22);
      if (i == 49) begin
        checks++; if (credit !== 8'd250) begin failures++; $display("FAIL sat_credit_50: got %0d expected 250", credit); end
      end
    end
    checks++; if (credit !== 8'd255) begin failures++; $display("FAIL sat_credit_final: got %0d expected 255", credit); end
    checks++; if (tcount - n0 !== 300) begin failures++; $display("FAIL sat_tokens: got %0d expected 300", tcount - n0); end
  endtask

  task automatic test_reset_mid();
    int seen, n0, i0, c0, lat;
    do_reset();
    coin_sel = 2'b10;
    coin_in = 1'b1;
    seen = 0;
    for (int k = 0; k < 60 && seen < 3; k++) begin
      tick(1);
      if (T === 1'b1) seen++;
    end
    checks++; if (seen !== 3) begin failures++; $display("FAIL mid_third_token: got %0d expected 3", seen); end
    checks++; if (credit !== 8'd3) begin failures++; $display("FAIL mid_credit_before: got %0d expected 3", credit); end
    rst = 1'b0;
    #1;
    checks++; if (T !== 1'b0) begin failures++; $display("FAIL mid_T: got %b expected 0", T); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (credit !== 8'd0) begin failures++; $display("FAIL mid_credit: got %0d expected 0", credit); end
    coin_in = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(3);
    n0 = tcount; i0 = t_times.size();
    coin_sel = 2'b01;
    c0 = cyc;
    coin_in = 1'b1;
    tick(20);
    coin_in = 1'b0;
    tick(15);
    lat = (t_times.size() > i0) ? t_times[i0] - c0 : -1;
    checks++; if (tcount - n0 !== 2) begin failures++; $display("FAIL mid_next_tokens: got %0d expected 2", tcount - n0); end
    checks++; if (lat !== 8) begin failures++; $display("FAIL mid_next_latency: got %0d expected 8", lat); end
    checks++; if (credit !== 8'd2) begin failures++; $display("FAIL mid_next_credit: got %0d expected 2", credit); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_denom5();
    test_glitch();
    test_invalid();
    test_jam();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coin_token_feeder.md
Name: coin_token_feeder

Overview:
- Upstream stage of the vending FSM. Conditions the raw coin-slot sensor and classifies the coin by its denomination code.
- Converts each accepted coin into a paced train of single-cycle token pulses on T, which the downstream vending FSM samples every clock.
- Also keeps a saturating running credit count and flags jammed or invalid coins.

Parameters:
- DEB_CYCLES, 4: cycles the synchronized coin_in must stay stable before an edge is accepted.
- JAM_CYCLES, 64: max cycles coin_in may stay high before a jam is declared.
- TOKEN_GAP, 2: idle cycles (T=0) between consecutive token pulses.
- CW, 8: credit counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- coin_in  in  1  raw coin-slot sensor, asynchronous, high while a coin is in the slot.
- coin_sel  in  2  denomination code, sampled at accept: 00=1 token, 01=2, 10=5, 11=invalid.
- T  out  1  token pulse to the vending FSM, one cycle high per token.
- busy  out  1  high from accept until the last token gap ends.
- credit  out  CW  total tokens emitted since reset, saturating at all-ones.
- err  out  1  sticky: set on jam or invalid code, cleared only by rst.

Behaviour:
- Reset: rst=0 asynchronously forces state IDLE, synchronizer flops 0, debounce and jam counters 0, token and gap counters 0. Outputs T=0, busy=0, credit=0, err=0.
- Synchronizer: 2-flop sync on coin_in giving cs. All logic uses only cs.
- State IDLE:
  - cs=1 → DEBOUNCE, debounce counter cleared.
- State DEBOUNCE:
  - Counter increments while cs=1.
  - cs=0 before count reaches DEB_CYCLES-1 → back to IDLE; the glitch is ignored with no other effect.
  - Count reaches DEB_CYCLES-1 with cs=1 → ACCEPT.
- State ACCEPT (one cycle):
  - Latch coin_sel.
  - Code 11 → set err, go to RELEASE, emit nothing.
  - Otherwise load the token counter with 1, 2 or 5, set busy=1, go to EMIT.
- State EMIT:
  - Drive T=1 for exactly one cycle, decrement the token counter, increment credit (saturating; stays at all-ones).
  - Then go to GAP.
- State GAP:
  - T=0 for TOKEN_GAP cycles.
  - Then return to EMIT if tokens remain; otherwise go to RELEASE, with busy=0 on the cycle RELEASE is entered.
- State RELEASE:
  - Wait until cs=0 stable for DEB_CYCLES consecutive cycles, then go to IDLE.
  - Any cs=1 restarts the stability count.
- Jam detection:
  - Jam counter runs whenever cs=1 outside IDLE and clears when cs=0.
  - Reaching JAM_CYCLES sets err and does not abort token emission already in progress.
  - RELEASE still waits for cs=0.
- Coin insertion during EMIT/GAP/RELEASE never starts a new coin; a new coin is recognised only from IDLE.
- Latency: first T pulse occurs 2 (sync) + DEB_CYCLES + 1 (ACCEPT) + 1 cycles after the coin_in rising edge. Token spacing is TOKEN_GAP+1 cycles.
- Reset mid-emission: remaining tokens are discarded; T drops immediately (asynchronously).
- T is registered, never combinational.

Decomposition:
- Shared package vend_pkg:
  - state encoding constants for IDLE, DEBOUNCE, ACCEPT, EMIT, GAP, RELEASE;
  - denomination code constants (COIN_1, COIN_2, COIN_5, COIN_BAD);
  - token-count lookup function.
- One natural sub-module, coin_debounce:
  - contains the 2-flop synchronizer plus the stability counter;
  - outputs cs and stable-high/stable-low strobes;
  - reused for both DEBOUNCE and RELEASE timing.
- Top level holds the FSM, the token/gap counters, credit and err.

Test Plan:
- Single coin: rst low then high; coin_in=1 for 20 cycles, coin_sel=00 → exactly one T pulse 8 cycles after the edge (defaults); credit=1, busy high for 4 cycles, err=0.
- Denomination 5: coin_sel=10, coin_in high 40 cycles → five T pulses spaced 3 cycles apart; credit=5; busy falls after the last gap.
- Glitch rejection: coin_in high for 2 cycles then low → no T pulse, credit unchanged, state returns to IDLE.
- Invalid code and jam:
  - coin_sel=11 → zero tokens, err=1.
  - Separately, coin_sel=00 held high 100 cycles → one token, err=1 at the jam threshold; the next coin is accepted only after 4 stable low cycles.
- Saturation: insert 60 five-token coins with CW=8 → credit stops at 255 while T pulses continue.
- Reset mid-emission: assert rst during the 3rd token of a 5-token coin → T=0, busy=0, credit=0 immediately; the next coin behaves normally.
